// File: rtl/counter_mod_n_presc_if.sv
// Control/status bundle for counter_mod_n_presc: run/direction/load controls in, count/wrap/tick out.
interface counter_mod_n_presc_if #(
    parameter int WIDTH = 4
);
    logic             En;
    logic             Up;
    logic             Load;
    logic [WIDTH-1:0] Load_Val;
    logic [WIDTH-1:0] Count;
    logic             Tc;
    logic             Tick;

    modport master (
        output En, Up, Load, Load_Val,
        input  Count, Tc, Tick
    );

    modport slave (
        input  En, Up, Load, Load_Val,
        output Count, Tc, Tick
    );
endinterface

// File: rtl/counter_mod_n_presc.sv
// Modulo-N up/down counter stepped by a one-cycle clock-enable prescaler tick.
// Build option: define COUNTER_PRESCALER_EN for the DIV prescaler; undefined steps every enabled cycle.
module counter_mod_n_presc #(
    parameter int WIDTH   = 4,
    parameter int MODULUS = 16,
    parameter int DIV     = 100_000_000
) (
    input  logic                   Clk,
    input  logic                   Reset,
    counter_mod_n_presc_if.slave   bus
);

    if ((MODULUS < 2) || (MODULUS > (2 ** WIDTH))) begin : g_bad_modulus
        $error("counter_mod_n_presc: MODULUS must satisfy 2 <= MODULUS <= 2**WIDTH");
    end

    if (DIV < 1) begin : g_bad_div
        $error("counter_mod_n_presc: DIV must be at least 1");
    end

    localparam logic [WIDTH-1:0] MAX_C = WIDTH'(MODULUS - 1);

    // Out-of-range load values saturate to the top of the count range.
    function automatic logic [WIDTH-1:0] clamp_load(input logic [WIDTH-1:0] v);
        logic [WIDTH-1:0] r;
        if (v > MAX_C) begin
            r = MAX_C;
        end else begin
            r = v;
        end
        return r;
    endfunction

    logic             tick_s;
    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;
    logic             tc_q;
    logic             tc_d;

`ifdef COUNTER_PRESCALER_EN
    localparam int               DIV_W    = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);

    logic [DIV_W-1:0] div_q;
    logic [DIV_W-1:0] div_d;

    // Tick on the last prescaler phase; suppressed by reset and load.
    always_comb begin
        tick_s = bus.En & (div_q == DIV_LAST) & ~Reset & ~bus.Load;
    end

    // Prescaler next state: load discards the partial count, En=0 freezes it.
    always_comb begin
        div_d = div_q;
        if (bus.Load) begin
            div_d = {DIV_W{1'b0}};
        end else if (bus.En) begin
            if (div_q == DIV_LAST) begin
                div_d = {DIV_W{1'b0}};
            end else begin
                div_d = div_q + DIV_W'(1);
            end
        end else begin
            div_d = div_q;
        end
    end

    // Prescaler register.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            div_q <= {DIV_W{1'b0}};
        end else begin
            div_q <= div_d;
        end
    end
`else
    // Without the prescaler every enabled cycle is a step.
    always_comb begin
        tick_s = bus.En & ~Reset & ~bus.Load;
    end
`endif

    // Count next state: load beats a coincident tick; wraps raise Tc for one cycle.
    always_comb begin
        count_d = count_q;
        tc_d    = 1'b0;
        if (bus.Load) begin
            count_d = clamp_load(bus.Load_Val);
        end else if (tick_s) begin
            if (bus.Up) begin
                if (count_q == MAX_C) begin
                    count_d = {WIDTH{1'b0}};
                    tc_d    = 1'b1;
                end else begin
                    count_d = count_q + WIDTH'(1);
                end
            end else begin
                if (count_q == {WIDTH{1'b0}}) begin
                    count_d = MAX_C;
                    tc_d    = 1'b1;
                end else begin
                    count_d = count_q - WIDTH'(1);
                end
            end
        end else begin
            count_d = count_q;
        end
    end

    // Count and terminal-count registers.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            count_q <= {WIDTH{1'b0}};
            tc_q    <= 1'b0;
        end else begin
            count_q <= count_d;
            tc_q    <= tc_d;
        end
    end

    assign bus.Count = count_q;
    assign bus.Tc    = tc_q;
    assign bus.Tick  = tick_s;

endmodule
